// File: rtl/ab_seq_pkg.sv
// Shared types for the a/b/x stimulus sequencer.
//   state_e : sequencer FSM states
//   cmd_t   : one queued command {dly, x, nob}
package ab_seq_pkg;

  localparam int unsigned CMD_XW      = 6;
  localparam int unsigned DLY_W       = 3;
  localparam int unsigned DEF_MAX_DLY = 5;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT_A = 2'd1,
    WAIT     = 2'd2,
    ASSERT_B = 2'd3
  } state_e;

  typedef struct packed {
    logic [DLY_W-1:0]  dly;
    logic [CMD_XW-1:0] x;
    logic              nob;
  } cmd_t;

  // A delay is usable only in 1..max_dly.
  function automatic logic dly_legal(input logic [DLY_W-1:0] dly, input int unsigned max_dly);
    return (dly != '0) && (32'(dly) <= max_dly);
  endfunction

endpackage

// File: rtl/ab_cmd_fifo.sv
// Synchronous show-ahead command FIFO.
//   clk, rst     : clock, synchronous active-high reset (flushes pointers/count)
//   push, din    : write request and data (ignored when full)
//   pop          : read request (ignored when empty)
//   head_c       : entry at the read pointer (valid when !empty_c)
//   empty_c      : FIFO holds no entries
//   count_nxt_c  : occupancy after this cycle's push/pop
module ab_cmd_fifo
  import ab_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     head_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign empty_c = (count == '0);
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Next occupancy, shared with the parent for its registered ready/busy.
  always_comb begin
    count_nxt_c = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt_c = count + CW'(1);
      2'b01:   count_nxt_c = count - CW'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
    end
  end

  // Storage needs no reset; the flushed pointers make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ab_seq_driver.sv
// Stimulus sequencer: replays queued commands as a pulse, dly-cycle gap, b pulse.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready = FIFO not full, registered)
//   cmd_dly/cmd_x/cmd_nob : a->b delay, x value, suppress-b flag
//   a, b                : one-cycle pulses
//   x                   : data loaded with each a pulse, held otherwise
//   busy                : sequencer active or commands queued
//   hit_cnt/miss_cnt    : saturating counts of driven / suppressed b
//   err_dly             : sticky flag for a popped illegal delay
module ab_seq_driver
  import ab_seq_pkg::*;
#(
  parameter int unsigned XW      = CMD_XW,
  parameter int unsigned MAX_DLY = DEF_MAX_DLY,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DLY_W-1:0] cmd_dly,
  input  logic [XW-1:0]    cmd_x,
  input  logic             cmd_nob,
  output logic             a,
  output logic             b,
  output logic [XW-1:0]    x,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err_dly
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e           state;
  state_e           next_state;
  logic [DLY_W-1:0] wcnt;
  logic [DLY_W-1:0] wcnt_nxt;
  logic [DLY_W-1:0] cur_dly;
  logic             cur_nob;
  logic             push_fire;
  logic             pop;
  logic             load_cmd;
  logic             set_err;
  cmd_t             cmd_in;
  cmd_t             head_c;
  logic             empty_c;
  logic [CW-1:0]    count_nxt;

  assign push_fire = cmd_valid && cmd_ready;
  assign cmd_in    = '{dly: cmd_dly, x: CMD_XW'(cmd_x), nob: cmd_nob};

  ab_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_fire),
    .din         (cmd_in),
    .pop         (pop),
    .head_c      (head_c),
    .empty_c     (empty_c),
    .count_nxt_c (count_nxt)
  );

  // Next-state logic; IDLE and ASSERT_B both try to start the next command.
  always_comb begin
    next_state = state;
    wcnt_nxt   = wcnt;
    pop        = 1'b0;
    load_cmd   = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE, ASSERT_B: begin
        if (state == ASSERT_B) next_state = IDLE;
        if (!empty_c) begin
          pop = 1'b1;
          if (dly_legal(head_c.dly, MAX_DLY)) begin
            load_cmd   = 1'b1;
            next_state = ASSERT_A;
          end else begin
            set_err    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ASSERT_A: begin
        if (cur_dly == DLY_W'(1)) begin
          next_state = ASSERT_B;
        end else begin
          // WAIT lasts dly-1 cycles, counting dly-2 down to 0.
          wcnt_nxt   = cur_dly - DLY_W'(2);
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == '0) next_state = ASSERT_B;
        else            wcnt_nxt   = wcnt - DLY_W'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  // State and registered outputs; pulses are decoded from next_state so they
  // coincide with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      cur_dly   <= '0;
      cur_nob   <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      x         <= '0;
      busy      <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      err_dly   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state <= next_state;
      wcnt  <= wcnt_nxt;
      if (load_cmd) begin
        cur_dly <= head_c.dly;
        cur_nob <= head_c.nob;
        x       <= XW'(head_c.x);
      end
      a <= (next_state == ASSERT_A);
      b <= (next_state == ASSERT_B) && !cur_nob;
      if (next_state == ASSERT_B) begin
        if (!cur_nob) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
      end
      if (set_err) err_dly <= 1'b1;
      busy      <= (next_state != IDLE) || (count_nxt != '0);
      cmd_ready <= (count_nxt != CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ab_seq_driver.sv
// Directed bench for ab_seq_driver: cycle traces of a/b/ready/busy/err per scenario.
module tb_ab_seq_driver;
  import ab_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_dly = '0;
  logic [5:0] cmd_x = '0;
  logic       cmd_nob = 1'b0;
  logic       a, b, busy, err_dly;
  logic [5:0] x;
  logic [7:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;
  int cov = 0;
  int since_a = 1000;
  cmd_t pend[$];

  ab_seq_driver dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dly(cmd_dly), .cmd_x(cmd_x), .cmd_nob(cmd_nob),
    .a(a), .b(b), .x(x), .busy(busy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_dly(err_dly)
  );

  always #5 clk = ~clk;

  // Reference cover for a ##[1:5] b, evaluated on sampled values.
  always @(posedge clk) begin
    if (b && since_a >= 1 && since_a <= 5) cov <= cov + 1;
    if (a) since_a <= 1;
    else if (since_a < 1000) since_a <= since_a + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] d, input logic [5:0] xx, input logic n);
    cmd_t cm;
    cm.dly = d;
    cm.x   = xx;
    cm.nob = n;
    pend.push_back(cm);
  endtask

  // Offers queued commands; cycle 0 is the current cycle. Records traces.
  task automatic run(input int n, input int rst_cyc,
                     output logic [31:0] at, output logic [31:0] bt,
                     output logic [31:0] rt, output logic [31:0] yt,
                     output logic [31:0] et);
    at = '0; bt = '0; rt = '0; yt = '0; et = '0;
    for (int c = 0; c < n; c++) begin
      rst = (c == rst_cyc);
      if (pend.size() > 0) begin
        cmd_valid = 1'b1;
        cmd_dly   = pend[0].dly;
        cmd_x     = pend[0].x;
        cmd_nob   = pend[0].nob;
      end else begin
        cmd_valid = 1'b0;
      end
      if (c < 32) begin
        at[c] = a; bt[c] = b; rt[c] = cmd_ready; yt[c] = busy; et[c] = err_dly;
      end
      if (cmd_valid && cmd_ready) pend.delete(0);
      tick();
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({a, b, busy, cmd_ready, err_dly} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {a, b, busy, cmd_ready, err_dly});
    end
    checks++;
    if ({x, hit_cnt, miss_cnt} !== 22'h0) begin
      errors++;
      $display("FAIL reset_data: got x=%h hit=%h miss=%h expected all 0", x, hit_cnt, miss_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] at, bt, rt, yt, et;
    int c0;
    c0 = cov;
    add(3'd1, 6'h14, 1'b0);
    run(5, -1, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h04 || bt !== 32'h08) begin
      errors++;
      $display("FAIL single_ab: got a=%h b=%h expected a=04 b=08", at, bt);
    end
    checks++;
    if (yt !== 32'h0E) begin
      errors++;
      $display("FAIL single_busy: got %h expected 0e", yt);
    end
    checks++;
    if (x !== 6'h14 || hit_cnt !== 8'd1 || cov !== c0 + 1) begin
      errors++;
      $display("FAIL single_state: got x=%h hit=%0d cover+%0d expected x=14 hit=1 cover+1",
               x, hit_cnt, cov - c0);
    end
  endtask

  task automatic test_long_delay();
    logic [31:0] at, bt, rt, yt, et;
    int c0;
    c0 = cov;
    add(3'd5, 6'h2A, 1'b0);
    run(10, -1, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h004 || bt !== 32'h080) begin
      errors++;
      $display("FAIL long_ab: got a=%h b=%h expected a=004 b=080", at, bt);
    end
    checks++;
    if (x !== 6'h2A || hit_cnt !== 8'd2 || cov !== c0 + 1) begin
      errors++;
      $display("FAIL long_state: got x=%h hit=%0d cover+%0d expected x=2a hit=2 cover+1",
               x, hit_cnt, cov - c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] at, bt, rt, yt, et;
    int c0;
    c0 = cov;
    add(3'd5, 6'h01, 1'b0);
    for (int i = 0; i < 5; i++) add(3'd1, 6'(i + 2), 1'b0);
    run(22, -1, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h15504 || bt !== 32'h2AA80) begin
      errors++;
      $display("FAIL b2b_ab: got a=%h b=%h expected a=15504 b=2aa80", at, bt);
    end
    checks++;
    if (rt[8:5] !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_ready: got ready[8:5]=%b expected 1000", rt[8:5]);
    end
    checks++;
    if (hit_cnt !== 8'd8 || x !== 6'h06 || cov !== c0 + 6 || pend.size() != 0) begin
      errors++;
      $display("FAIL b2b_state: got hit=%0d x=%h cover+%0d left=%0d expected 8 06 +6 0",
               hit_cnt, x, cov - c0, pend.size());
    end
  endtask

  task automatic test_nob();
    logic [31:0] at, bt, rt, yt, et;
    int c0;
    c0 = cov;
    add(3'd3, 6'h3F, 1'b1);
    run(8, -1, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h04 || bt !== 32'h00) begin
      errors++;
      $display("FAIL nob_ab: got a=%h b=%h expected a=04 b=00", at, bt);
    end
    checks++;
    if (miss_cnt !== 8'd1 || hit_cnt !== 8'd8 || cov !== c0) begin
      errors++;
      $display("FAIL nob_counts: got miss=%0d hit=%0d cover+%0d expected 1 8 +0",
               miss_cnt, hit_cnt, cov - c0);
    end
  endtask

  task automatic test_illegal_dly();
    logic [31:0] at, bt, rt, yt, et;
    add(3'd0, 6'h01, 1'b0);
    add(3'd6, 6'h02, 1'b0);
    add(3'd2, 6'h15, 1'b0);
    run(10, -1, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h10 || bt !== 32'h40) begin
      errors++;
      $display("FAIL illegal_ab: got a=%h b=%h expected a=10 b=40", at, bt);
    end
    checks++;
    if (et[2:1] !== 2'b10 || err_dly !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err: got err[2:1]=%b now=%b expected 10 1", et[2:1], err_dly);
    end
    checks++;
    if (x !== 6'h15 || hit_cnt !== 8'd9) begin
      errors++;
      $display("FAIL illegal_state: got x=%h hit=%0d expected 15 9", x, hit_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] at, bt, rt, yt, et;
    add(3'd4, 6'h11, 1'b0);
    add(3'd1, 6'h12, 1'b0);
    add(3'd1, 6'h13, 1'b0);
    run(9, 4, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h004 || bt !== 32'h000) begin
      errors++;
      $display("FAIL rst_ab: got a=%h b=%h expected a=004 b=000", at, bt);
    end
    checks++;
    if (rt !== 32'h1DF || yt !== 32'h01E) begin
      errors++;
      $display("FAIL rst_ready_busy: got ready=%h busy=%h expected 1df 01e", rt, yt);
    end
    checks++;
    if ({x, hit_cnt, miss_cnt} !== 22'h0 || err_dly !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear: got x=%h hit=%h miss=%h err=%b expected all 0",
               x, hit_cnt, miss_cnt, err_dly);
    end
    add(3'd2, 6'h3C, 1'b0);
    run(7, -1, at, bt, rt, yt, et);
    checks++;
    if (at !== 32'h04 || bt !== 32'h10 || x !== 6'h3C || hit_cnt !== 8'd1) begin
      errors++;
      $display("FAIL rst_after: got a=%h b=%h x=%h hit=%0d expected 04 10 3c 1",
               at, bt, x, hit_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] at, bt, rt, yt, et;
    for (int i = 0; i < 254; i++) add(3'd1, 6'(i), 1'b0);
    run(700, -1, at, bt, rt, yt, et);
    checks++;
    if (hit_cnt !== 8'hFF || pend.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sat_fill: got hit=%h left=%0d busy=%b expected ff 0 0",
               hit_cnt, pend.size(), busy);
    end
    add(3'd1, 6'h2B, 1'b0);
    run(6, -1, at, bt, rt, yt, et);
    checks++;
    if (hit_cnt !== 8'hFF || bt !== 32'h08 || miss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_hold: got hit=%h b=%h miss=%0d expected ff 08 0",
               hit_cnt, bt, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_delay();
    test_back_to_back();
    test_nob();
    test_illegal_dly();
    test_mid_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
